sensor_reset_sequencer: RTL

- Power-up and re-arm sequencer for the image sensor, downstream of clock generation, in the oscillator clock domain.
- Waits for the PLL lock to be stable, then enables the sensor clock.
- Holds the sensor's active-low reset for a programmed time, releases it, then waits a settle time before flagging done.
- Drives the sensor reset pin and the done flag consumed by the sensor configuration logic.

---
 rtl/sensor_reset_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sensor_reset_sequencer.sv
// Image-sensor power-up / re-arm sequencer: waits for stable PLL lock, enables the
// sensor clock, pulses the active-low sensor reset, then flags done after a settle time.
module sensor_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES   = 1000,
    parameter int CLK_PRE_CYCLES       = 200,
    parameter int RESET_ASSERT_CYCLES  = 500,
    parameter int RESET_RELEASE_CYCLES = 2000,
    parameter int CNT_W                = 16
) (
    input  logic clk_osc_bufg,
    input  logic reset_osc_bufg,
    input  logic i_pll_lock,
    input  logic i_reset_sensor,
    output logic o_sensor_clk_en,
    output logic o_reset_senser_n,
    output logic o_sensor_reset_done,
    output logic o_busy
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_CLK_PRE   = 3'd1,
        ST_ASSERT    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Reload values are duration-1 so a state exits on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] LOCK_LOAD    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LOAD     = CNT_W'(CLK_PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(RESET_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RESET_RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             req_d1_r;
    logic             req_rise_s;
    logic             cnt_zero_s;
    logic             clk_en_s;
    logic             rst_n_s;
    logic             done_s;

    assign req_rise_s = i_reset_sensor & ~req_d1_r;
    assign cnt_zero_s = (cnt_r == CNT_ZERO);

    // Request edge detector; loads zero while the block is held in reset.
    always_ff @(posedge clk_osc_bufg) begin
        if (reset_osc_bufg) begin
            req_d1_r <= 1'b0;
        end else begin
            req_d1_r <= i_reset_sensor;
        end
    end

    // Next-state and counter logic; lock loss overrides requests and counter expiry.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r - CNT_ONE;
        if ((state_r != ST_WAIT_LOCK) && !i_pll_lock) begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = LOCK_LOAD;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (!i_pll_lock) begin
                        cnt_s = LOCK_LOAD;
                    end else if (cnt_zero_s) begin
                        state_s = ST_CLK_PRE;
                        cnt_s   = PRE_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_CLK_PRE: begin
                    if (cnt_zero_s) begin
                        state_s = ST_ASSERT;
                        cnt_s   = ASSERT_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_zero_s) begin
                        state_s = ST_RELEASE;
                        cnt_s   = RELEASE_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_zero_s) begin
                        state_s = ST_DONE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (req_rise_s) begin
                        state_s = ST_ASSERT;
                        cnt_s   = ASSERT_LOAD;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = LOCK_LOAD;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they change on the edge entering it;
    // reset release is only possible in states where the clock is already enabled.
    always_comb begin
        clk_en_s = (state_s != ST_WAIT_LOCK);
        rst_n_s  = (state_s == ST_RELEASE) || (state_s == ST_DONE);
        done_s   = (state_s == ST_DONE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_osc_bufg) begin
        if (reset_osc_bufg) begin
            state_r             <= ST_WAIT_LOCK;
            cnt_r               <= LOCK_LOAD;
            o_sensor_clk_en     <= 1'b0;
            o_reset_senser_n    <= 1'b0;
            o_sensor_reset_done <= 1'b0;
            o_busy              <= 1'b1;
        end else begin
            state_r             <= state_s;
            cnt_r               <= cnt_s;
            o_sensor_clk_en     <= clk_en_s;
            o_reset_senser_n    <= rst_n_s;
            o_sensor_reset_done <= done_s;
            o_busy              <= ~done_s;
        end
    end

endmodule
